// File: rtl/vga_pkg.sv
// Shared VGA text-overlay types and geometry: screen selector enum and
// character-cell dimensions of the 16x16 text window.
package vga_pkg;
  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_GAME  = 2'd1,
    S_END   = 2'd2
  } screen_t;

  localparam int TEXT_COLS = 16;
  localparam int TEXT_ROWS = 16;
  localparam int CHAR_W    = 8;
  localparam int CHAR_H    = 16;
  localparam int TEXT_W    = TEXT_COLS * CHAR_W;
  localparam int TEXT_H    = TEXT_ROWS * CHAR_H;
endpackage

// File: rtl/text_screen_ctl_if.sv
// Signal bundle between VGA timing, game logic, character ROMs and the
// text screen controller.
interface text_screen_ctl_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic        start_btn;
  logic        game_over;
  logic [6:0]  char_code_start;
  logic [6:0]  char_code_gra;
  logic [6:0]  char_code_gra2;
  logic [7:0]  char_xy;
  logic [6:0]  char_code;
  logic [3:0]  char_line;
  logic        in_text;
  logic [1:0]  screen;
  logic [10:0] hcount_d;
  logic [10:0] vcount_d;
  logic        hsync_d;
  logic        vsync_d;
  logic        hblnk_d;
  logic        vblnk_d;

  modport slave (
    input  hcount, vcount, hsync, vsync, hblnk, vblnk, start_btn, game_over,
           char_code_start, char_code_gra, char_code_gra2,
    output char_xy, char_code, char_line, in_text, screen,
           hcount_d, vcount_d, hsync_d, vsync_d, hblnk_d, vblnk_d
  );

  modport master (
    output hcount, vcount, hsync, vsync, hblnk, vblnk, start_btn, game_over,
           char_code_start, char_code_gra, char_code_gra2,
    input  char_xy, char_code, char_line, in_text, screen,
           hcount_d, vcount_d, hsync_d, vsync_d, hblnk_d, vblnk_d
  );
endinterface

// File: rtl/text_screen_ctl_screen_fsm.sv
// Screen sequencer: start -> game -> end -> start, with requests latched as
// pending and applied only on the cycle after a vblnk rising edge.
module screen_fsm
  import vga_pkg::*;
#(
  parameter logic [7:0] MIN_END_FRAMES = 8'd60
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    start_btn,
  input  logic    game_over,
  input  logic    vblnk,
  output screen_t screen
);
  screen_t    state, state_n, pending, pending_n, req_state;
  logic       pend_vld, pend_vld_n, req;
  logic [7:0] end_frames, end_frames_n;
  logic       btn_q, vblnk_q, press, vblnk_rise;

  assign press      = start_btn & ~btn_q;
  assign vblnk_rise = vblnk & ~vblnk_q;
  assign screen     = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_START;
      pending    <= S_START;
      pend_vld   <= 1'b0;
      end_frames <= 8'd0;
      btn_q      <= 1'b0;
      vblnk_q    <= 1'b0;
    end else begin
      state      <= state_n;
      pending    <= pending_n;
      pend_vld   <= pend_vld_n;
      end_frames <= end_frames_n;
      btn_q      <= start_btn;
      vblnk_q    <= vblnk;
    end
  end

  always_comb begin
    state_n      = state;
    pending_n    = pending;
    pend_vld_n   = pend_vld;
    end_frames_n = end_frames;
    req          = 1'b0;
    req_state    = pending;

    if (vblnk_rise && pend_vld) begin
      state_n    = pending;
      pend_vld_n = 1'b0;
    end

    case (state)
      S_START: if (press) begin req = 1'b1; req_state = S_GAME; end
      S_GAME:  if (game_over) begin req = 1'b1; req_state = S_END; end
      S_END:   if (press && end_frames >= MIN_END_FRAMES) begin
                 req = 1'b1; req_state = S_START;
               end
      default: state_n = S_START;
    endcase

    // A request raised on the boundary cycle itself re-arms for the next frame
    if (req) begin
      pending_n  = req_state;
      pend_vld_n = 1'b1;
    end

    if (state_n == S_END && state != S_END)
      end_frames_n = 8'd0;
    else if (state == S_END && vblnk_rise && end_frames != 8'hFF)
      end_frames_n = end_frames + 8'd1;
  end
endmodule

// File: rtl/text_screen_ctl.sv
// Text overlay sequencer: cell addressing, per-screen ROM selection and a
// two-stage pipeline keeping code, window flag and VGA timing aligned.
module text_screen_ctl
  import vga_pkg::*;
#(
  parameter logic [10:0] X0             = 11'd448,
  parameter logic [10:0] Y0             = 11'd256,
  parameter logic [7:0]  MIN_END_FRAMES = 8'd60
) (
  input logic             clk,
  input logic             rst,
  text_screen_ctl_if.slave bus
);
  screen_t     screen;
  logic [10:0] dx, dy;
  logic        in_win;
  logic [7:0]  xy_c;
  logic [3:0]  line_c;
  logic [6:0]  code_sel;

  logic [7:0]  xy_p1;
  logic [3:0]  line_p1;
  logic        in_p1, hsync_p1, vsync_p1, hblnk_p1, vblnk_p1;
  logic [10:0] hcount_p1, vcount_p1;

  logic [6:0]  code_p2;
  logic        in_p2, hsync_p2, vsync_p2, hblnk_p2, vblnk_p2;
  logic [10:0] hcount_p2, vcount_p2;

  screen_fsm #(.MIN_END_FRAMES(MIN_END_FRAMES)) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .start_btn (bus.start_btn),
    .game_over (bus.game_over),
    .vblnk     (bus.vblnk),
    .screen    (screen)
  );

  // Counters left of / above the window underflow to large offsets and fail the test
  always_comb begin
    dx     = bus.hcount - X0;
    dy     = bus.vcount - Y0;
    in_win = (dx < 11'(TEXT_W)) && (dy < 11'(TEXT_H));
    xy_c   = in_win ? {dy[7:4], dx[6:3]} : 8'd0;
    line_c = in_win ? dy[3:0] : 4'd0;
  end

  always_comb begin
    case (screen)
      S_START: code_sel = bus.char_code_start;
      S_GAME:  code_sel = bus.char_code_gra;
      S_END:   code_sel = bus.char_code_gra2;
      default: code_sel = 7'd0;
    endcase
  end

  // Stage 1: cell address, font row, window flag, timing
  always_ff @(posedge clk) begin
    if (rst) begin
      xy_p1 <= '0; line_p1 <= '0; in_p1 <= 1'b0;
      hcount_p1 <= '0; vcount_p1 <= '0;
      hsync_p1 <= 1'b0; vsync_p1 <= 1'b0; hblnk_p1 <= 1'b0; vblnk_p1 <= 1'b0;
    end else begin
      xy_p1 <= xy_c; line_p1 <= line_c; in_p1 <= in_win;
      hcount_p1 <= bus.hcount; vcount_p1 <= bus.vcount;
      hsync_p1 <= bus.hsync; vsync_p1 <= bus.vsync;
      hblnk_p1 <= bus.hblnk; vblnk_p1 <= bus.vblnk;
    end
  end

  // Stage 2: ROM code for the current screen, stage-1 data carried along
  always_ff @(posedge clk) begin
    if (rst) begin
      code_p2 <= '0; in_p2 <= 1'b0;
      hcount_p2 <= '0; vcount_p2 <= '0;
      hsync_p2 <= 1'b0; vsync_p2 <= 1'b0; hblnk_p2 <= 1'b0; vblnk_p2 <= 1'b0;
    end else begin
      code_p2 <= in_p1 ? code_sel : 7'd0;
      in_p2   <= in_p1;
      hcount_p2 <= hcount_p1; vcount_p2 <= vcount_p1;
      hsync_p2 <= hsync_p1; vsync_p2 <= vsync_p1;
      hblnk_p2 <= hblnk_p1; vblnk_p2 <= vblnk_p1;
    end
  end

  assign bus.char_xy   = xy_p1;
  assign bus.char_line = line_p1;
  assign bus.char_code = code_p2;
  assign bus.in_text   = in_p2;
  assign bus.screen    = screen;
  assign bus.hcount_d  = hcount_p2;
  assign bus.vcount_d  = vcount_p2;
  assign bus.hsync_d   = hsync_p2;
  assign bus.vsync_d   = vsync_p2;
  assign bus.hblnk_d   = hblnk_p2;
  assign bus.vblnk_d   = vblnk_p2;
endmodule

// File: tb/tb_text_screen_ctl.sv
// Directed bench for text_screen_ctl: addressing, window edges, screen
// sequencing at frame boundaries, end-screen hold time and mid-frame reset.
module tb_text_screen_ctl;
  logic clk = 1'b0;
  logic rst;
  int   nchk  = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  text_screen_ctl_if bus();

  // ROM models: code is the cell address XORed with a per-screen key
  assign bus.char_code_start = bus.char_xy[6:0] ^ 7'h15;
  assign bus.char_code_gra   = bus.char_xy[6:0] ^ 7'h2A;
  assign bus.char_code_gra2  = bus.char_xy[6:0] ^ 7'h4C;

  text_screen_ctl #(.X0(11'd448), .Y0(11'd256), .MIN_END_FRAMES(8'd60)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    bus.vblnk = 1'b1; tick();
    bus.vblnk = 1'b0; tick(); tick();
  endtask

  task automatic press();
    bus.start_btn = 1'b1; tick();
    bus.start_btn = 1'b0; tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.hcount = '0; bus.vcount = '0;
    bus.hsync = 1'b0; bus.vsync = 1'b0; bus.hblnk = 1'b0; bus.vblnk = 1'b0;
    bus.start_btn = 1'b0; bus.game_over = 1'b0;
    tick(); tick();
    nchk++; if (bus.screen !== 2'd0) begin nfail++; $display("FAIL reset_screen: got %0d want 0", bus.screen); end
    nchk++; if (bus.char_xy !== 8'h00) begin nfail++; $display("FAIL reset_xy: got %h want 00", bus.char_xy); end
    nchk++; if (bus.char_code !== 7'h00) begin nfail++; $display("FAIL reset_code: got %h want 00", bus.char_code); end
    nchk++; if (bus.in_text !== 1'b0) begin nfail++; $display("FAIL reset_in_text: got %b want 0", bus.in_text); end
    nchk++; if (bus.hcount_d !== 11'd0 || bus.hsync_d !== 1'b0) begin
      nfail++; $display("FAIL reset_timing: got hcount_d=%0d hsync_d=%b want 0/0", bus.hcount_d, bus.hsync_d);
    end
    rst = 1'b0;
    frame();
    nchk++; if (bus.screen !== 2'd0) begin nfail++; $display("FAIL reset_no_pending: got %0d want 0", bus.screen); end
  endtask

  task automatic test_window();
    bus.hcount = 11'd456; bus.vcount = 11'd273; bus.hsync = 1'b1;
    tick();
    nchk++; if (bus.char_xy !== 8'h11) begin nfail++; $display("FAIL addr_xy: got %h want 11", bus.char_xy); end
    nchk++; if (bus.char_line !== 4'd1) begin nfail++; $display("FAIL addr_line: got %0d want 1", bus.char_line); end
    nchk++; if (bus.in_text !== 1'b0 || bus.hsync_d !== 1'b0) begin
      nfail++; $display("FAIL latency_early: got in_text=%b hsync_d=%b want 0/0", bus.in_text, bus.hsync_d);
    end
    tick();
    nchk++; if (bus.char_code !== 7'h04) begin nfail++; $display("FAIL code_start: got %h want 04", bus.char_code); end
    nchk++; if (bus.in_text !== 1'b1) begin nfail++; $display("FAIL in_text_inside: got %b want 1", bus.in_text); end
    nchk++; if (bus.hcount_d !== 11'd456 || bus.vcount_d !== 11'd273 || bus.hsync_d !== 1'b1) begin
      nfail++; $display("FAIL timing_d: got %0d/%0d/%b want 456/273/1", bus.hcount_d, bus.vcount_d, bus.hsync_d);
    end
    bus.hcount = 11'd575; bus.vcount = 11'd511; bus.hsync = 1'b0;
    tick(); tick();
    nchk++; if (bus.char_xy !== 8'hFF || bus.char_line !== 4'hF) begin
      nfail++; $display("FAIL corner_addr: got xy=%h line=%h want ff/f", bus.char_xy, bus.char_line);
    end
    nchk++; if (bus.char_code !== 7'h6A || bus.in_text !== 1'b1) begin
      nfail++; $display("FAIL corner_code: got code=%h in=%b want 6a/1", bus.char_code, bus.in_text);
    end
    bus.hcount = 11'd447; bus.vcount = 11'd273;
    tick(); tick();
    nchk++; if (bus.in_text !== 1'b0 || bus.char_code !== 7'h00 || bus.char_xy !== 8'h00) begin
      nfail++; $display("FAIL left_edge: got in=%b code=%h xy=%h want 0/00/00", bus.in_text, bus.char_code, bus.char_xy);
    end
    bus.hcount = 11'd576;
    tick(); tick();
    nchk++; if (bus.in_text !== 1'b0 || bus.char_code !== 7'h00) begin
      nfail++; $display("FAIL right_edge: got in=%b code=%h want 0/00", bus.in_text, bus.char_code);
    end
    bus.hcount = 11'd456; bus.vcount = 11'd255;
    tick(); tick();
    nchk++; if (bus.in_text !== 1'b0 || bus.char_line !== 4'd0) begin
      nfail++; $display("FAIL top_edge: got in=%b line=%0d want 0/0", bus.in_text, bus.char_line);
    end
    bus.vcount = 11'd273;
    tick(); tick();
  endtask

  task automatic test_start_press();
    press();
    nchk++; if (bus.screen !== 2'd0) begin nfail++; $display("FAIL start_midframe: got %0d want 0", bus.screen); end
    frame();
    nchk++; if (bus.screen !== 2'd1) begin nfail++; $display("FAIL start_to_game: got %0d want 1", bus.screen); end
    nchk++; if (bus.char_code !== 7'h3B) begin nfail++; $display("FAIL code_game: got %h want 3b", bus.char_code); end
  endtask

  task automatic test_game();
    press();
    frame();
    nchk++; if (bus.screen !== 2'd1) begin nfail++; $display("FAIL game_press_ignored: got %0d want 1", bus.screen); end
    bus.game_over = 1'b1; bus.start_btn = 1'b1; bus.vblnk = 1'b1;
    tick();
    nchk++; if (bus.screen !== 2'd1) begin nfail++; $display("FAIL same_cycle_deferred: got %0d want 1", bus.screen); end
    bus.game_over = 1'b0; bus.start_btn = 1'b0; bus.vblnk = 1'b0;
    tick(); tick();
    nchk++; if (bus.screen !== 2'd1) begin nfail++; $display("FAIL game_hold: got %0d want 1", bus.screen); end
    frame();
    nchk++; if (bus.screen !== 2'd2) begin nfail++; $display("FAIL game_to_end: got %0d want 2", bus.screen); end
    nchk++; if (bus.char_code !== 7'h5D) begin nfail++; $display("FAIL code_end: got %h want 5d", bus.char_code); end
    frame();
    nchk++; if (bus.screen !== 2'd2) begin nfail++; $display("FAIL end_stable: got %0d want 2", bus.screen); end
  endtask

  task automatic test_end_hold();
    for (int i = 0; i < 9; i++) frame();
    press();
    frame();
    nchk++; if (bus.screen !== 2'd2) begin nfail++; $display("FAIL end_early_10: got %0d want 2", bus.screen); end
    for (int i = 0; i < 48; i++) frame();
    press();
    frame();
    nchk++; if (bus.screen !== 2'd2) begin nfail++; $display("FAIL end_early_59: got %0d want 2", bus.screen); end
    press();
    nchk++; if (bus.screen !== 2'd2) begin nfail++; $display("FAIL end_midframe: got %0d want 2", bus.screen); end
    frame();
    nchk++; if (bus.screen !== 2'd0) begin nfail++; $display("FAIL end_to_start: got %0d want 0", bus.screen); end
  endtask

  task automatic test_reset_mid();
    press();
    frame();
    nchk++; if (bus.screen !== 2'd1) begin nfail++; $display("FAIL reenter_game: got %0d want 1", bus.screen); end
    bus.hsync = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick();
    nchk++; if (bus.screen !== 2'd0) begin nfail++; $display("FAIL midrst_screen: got %0d want 0", bus.screen); end
    nchk++; if (bus.char_xy !== 8'h00 || bus.char_line !== 4'd0) begin
      nfail++; $display("FAIL midrst_addr: got xy=%h line=%0d want 00/0", bus.char_xy, bus.char_line);
    end
    nchk++; if (bus.char_code !== 7'h00 || bus.in_text !== 1'b0) begin
      nfail++; $display("FAIL midrst_code: got code=%h in=%b want 00/0", bus.char_code, bus.in_text);
    end
    nchk++; if (bus.hcount_d !== 11'd0 || bus.vcount_d !== 11'd0 || bus.hsync_d !== 1'b0) begin
      nfail++; $display("FAIL midrst_timing: got %0d/%0d/%b want 0/0/0", bus.hcount_d, bus.vcount_d, bus.hsync_d);
    end
    rst = 1'b0;
    tick();
    nchk++; if (bus.char_xy !== 8'h11) begin nfail++; $display("FAIL refill_xy: got %h want 11", bus.char_xy); end
    tick();
    nchk++; if (bus.char_code !== 7'h04 || bus.in_text !== 1'b1 || bus.hsync_d !== 1'b1) begin
      nfail++; $display("FAIL refill_out: got code=%h in=%b hsync_d=%b want 04/1/1", bus.char_code, bus.in_text, bus.hsync_d);
    end
  endtask

  initial begin
    test_reset();
    test_window();
    test_start_press();
    test_game();
    test_end_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/text_screen_ctl.md
# text_screen_ctl

Sequencer and screen arbiter for the 16x16-cell character text overlay. Tracks which screen is active (start, game, end), switching only at frame boundaries. From VGA counters it generates the cell address `char_xy` shared by the per-screen character ROMs, selects the matching ROM's `char_code`, and delays VGA timing so that code, font line and syncs leave aligned. Sits between the VGA timing generator and the font ROM / character-draw stage.

## Interface
Parameters:
- `X0`, 11'd448: left pixel column of the text window.
- `Y0`, 11'd256: top pixel row of the text window.
- `MIN_END_FRAMES`, 8'd60: frames the end screen is held before `start_btn` is accepted.

Ports:
- `clk`  in  1  pixel clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `hcount`, `vcount`  in  11 each  VGA pixel counters.
- `hsync`, `vsync`, `hblnk`, `vblnk`  in  1 each  VGA timing.
- `start_btn`  in  1  debounced, synchronised button level.
- `game_over`  in  1  level from game logic.
- `char_code_start`, `char_code_gra`, `char_code_gra2`  in  7 each  ROM outputs for the start, game and end screens. The ROMs are combinational on `char_xy`.
- `char_xy`  out  8  cell address `{row[3:0], col[3:0]}`, shared by all ROMs.
- `char_code`  out  7  selected character code.
- `char_line`  out  4  font row within the glyph.
- `in_text`  out  1  pixel is inside the 128x256 text window.
- `screen`  out  2  active screen: 0 start, 1 game, 2 end.
- `hcount_d`, `vcount_d`  out  11 each  counters delayed 2 cycles.
- `hsync_d`, `vsync_d`, `hblnk_d`, `vblnk_d`  out  1 each  timing delayed 2 cycles.

## Operation
- Window test: `hcount` in [X0, X0+128) and `vcount` in [Y0, Y0+256).
- Offsets: `dx = hcount - X0`, `dy = vcount - Y0`, both 11-bit unsigned.
  - col = `dx[6:3]`, row = `dy[7:4]`, `char_line` = `dy[3:0]`.
  - Outside the window: `char_xy` = 0, `char_line` = 0, `in_text` = 0.
- Pipeline:
  - Stage 1 registers `char_xy`, `char_line`, the window flag and timing.
  - Stage 2 registers `char_code`, chosen by `screen` as it stands at that edge, plus the stage-1 data.
  - Outside the window, `char_code` = 0.
- Screen FSM states: S_START, S_GAME, S_END.
  - Button edge: `start_btn` is edge-detected; one press equals one rising edge.
  - S_START, press: `pending` = S_GAME.
  - S_GAME, `game_over` high: `pending` = S_END. Presses are ignored in S_GAME.
  - S_END, press while `end_frames >= MIN_END_FRAMES`: `pending` = S_START. Earlier presses are dropped, not queued.
  - Apply: on the cycle after a `vblnk` rising edge, state <= pending and the pending-valid flag clears.
  - A second request in the same frame overwrites `pending`; last wins.
- End-frame counter `end_frames`, 8 bits:
  - Clears on entry to S_END.
  - Increments on each `vblnk` rising edge while in S_END.
  - Saturates at 255.

## Timing
- Reset values:
  - All outputs 0, including the delayed timing.
  - `screen` = 0 (S_START); pending flag clear; `end_frames` = 0; edge-detect history = 0.
- Latency:
  - `char_xy` and `char_line`: 1 cycle after the counters.
  - `char_code`, `in_text` and all `*_d` outputs: exactly 2 cycles after the counters, mutually aligned.
- `screen` changes only on the cycle after a `vblnk` rising edge, so it never changes mid-frame.
- A request in the same cycle as the `vblnk` rise is applied at the next frame boundary, not this one.
- `rst` mid-frame: the next edge restores reset values; the pipeline refills within 2 cycles.
- `hcount` and `vcount` wrap at screen limits. Values below X0/Y0 underflow to large `dx`/`dy` and fall outside the window.

## Structure
- Add to `vga_pkg`:
  - `screen_t` enum (S_START=0, S_GAME=1, S_END=2).
  - Constants `TEXT_COLS=16`, `TEXT_ROWS=16`, `CHAR_W=8`, `CHAR_H=16`.
- Sub-module `screen_fsm`: edge detect, pending logic, `end_frames`, state register. It outputs `screen`.
- Address generation and the 2-stage pipeline stay in the top module.

## Test plan
- Reset then `hcount`=X0+8, `vcount`=Y0+17 -> after 1 cycle `char_xy`=8'h11, `char_line`=1; after 2 cycles `char_code`=`char_code_start`, `in_text`=1.
- `hcount`=X0-1 or X0+128 -> after 2 cycles `in_text`=0, `char_code`=0.
- Press in S_START mid-frame -> `screen` stays 0 until the cycle after the next `vblnk` rise, then 1.
- In S_GAME, assert `game_over` together with a button press -> `screen`=2 at the next frame boundary; the press is ignored.
- In S_END:
  - Press after 10 frames -> ignored.
  - Press after 60 frames -> `screen`=0 at the next boundary.
- Assert `rst` mid-frame in S_GAME -> next cycle `screen`=0 and all outputs 0.
